// File: rtl/dbg_pkg.sv
// Shared types, error codes and command-word field positions for the abstract-command engine.
package dbg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dbg_state_e;

   typedef enum logic [1:0] {
      KIND_GPR     = 2'd0,
      KIND_CSR     = 2'd1,
      KIND_INVALID = 2'd2
   } regno_kind_e;

   localparam logic [2:0] CMDERR_NONE       = 3'd0;
   localparam logic [2:0] CMDERR_BUSY       = 3'd1;
   localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
   localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
   localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

   localparam int CMD_TYPE_HI  = 31;
   localparam int CMD_TYPE_LO  = 24;
   localparam int CMD_SIZE_HI  = 22;
   localparam int CMD_SIZE_LO  = 20;
   localparam int CMD_POSTINC  = 19;
   localparam int CMD_TRANSFER = 17;
   localparam int CMD_WRITE    = 16;
   localparam int CMD_REGNO_HI = 15;

   // CSR space is 0..csr_limit; GPRs occupy 32 regnos starting at gpr_base.
   function automatic regno_kind_e regno_kind(input logic [15:0] regno,
                                              input logic [15:0] gpr_base,
                                              input logic [15:0] csr_limit);
      regno_kind_e kind;
      logic [16:0] gpr_top;
      gpr_top = {1'b0, gpr_base} + 17'd31;
      kind    = KIND_INVALID;
      if (regno <= csr_limit)
         kind = KIND_CSR;
      else if ((regno >= gpr_base) && ({1'b0, regno} <= gpr_top))
         kind = KIND_GPR;
      return kind;
   endfunction

endpackage

// File: rtl/dbg_abs_cmd.sv
// Abstract Access Register engine driving the core's halted-debug GPR/CSR port; DBG_AUTOINC_EN enables postinc.
// Latency: strobe one cycle after cmd_wr, data0 valid the cycle after, busy clears one cycle later.
// No backpressure: writes while busy are dropped and flagged as cmderr=busy.
module dbg_abs_cmd
   import dbg_pkg::*;
#(
   parameter logic [15:0] GPR_BASE  = 16'h1000,
   parameter logic [15:0] CSR_LIMIT = 16'h0fff
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_wr,
   input  logic [31:0] cmd,
   input  logic        data0_wr,
   input  logic [31:0] data0_wdata,
   output logic [31:0] data0,
   output logic        busy,
   output logic [2:0]  cmderr,
   input  logic [2:0]  cmderr_clr,
   output logic [15:0] regno_o,
   input  logic        halted,
   output logic [11:0] dbg_addr,
   output logic [31:0] dbg_wdata,
   output logic        dbg_gpr_rd,
   output logic        dbg_gpr_wr,
   input  logic [31:0] dbg_gpr_out,
   output logic        dbg_csr_rd,
   output logic        dbg_csr_wr,
   input  logic [31:0] dbg_csr_out
);

   dbg_state_e  state;
   logic        write_q;
   logic        is_gpr_q;
`ifdef DBG_AUTOINC_EN
   logic        postinc_q;
`endif

   logic [15:0] cmd_regno;
   logic [15:0] gpr_off;
   regno_kind_e kind;
   logic        fmt_ok;
   logic        accept;
   logic        access_en;
   logic [2:0]  cmderr_nxt;

   assign cmd_regno = cmd[CMD_REGNO_HI:0];
   assign gpr_off   = cmd_regno - GPR_BASE;
   assign kind      = regno_kind(cmd_regno, GPR_BASE, CSR_LIMIT);
   assign fmt_ok    = (cmd[CMD_TYPE_HI:CMD_TYPE_LO] == 8'd0) &&
                      (cmd[CMD_SIZE_HI:CMD_SIZE_LO] == 3'd2);
   assign accept    = (state == IDLE) && cmd_wr && (cmderr == CMDERR_NONE) &&
                      fmt_ok && halted && (kind != KIND_INVALID);

   // Strobes are combinational on halted so a hart leaving debug mid-access sees nothing.
   assign access_en  = (state == ACCESS) && halted;
   assign dbg_gpr_rd = access_en &&  is_gpr_q && !write_q;
   assign dbg_gpr_wr = access_en &&  is_gpr_q &&  write_q;
   assign dbg_csr_rd = access_en && !is_gpr_q && !write_q;
   assign dbg_csr_wr = access_en && !is_gpr_q &&  write_q;
   assign dbg_wdata  = data0;
   assign busy       = (state != IDLE);

   always_comb begin
      cmderr_nxt = cmderr;
      if (!cmd_wr)
         cmderr_nxt = cmderr & ~cmderr_clr;
      if (state == IDLE) begin
         if (cmd_wr && (cmderr == CMDERR_NONE)) begin
            if (!fmt_ok)
               cmderr_nxt = CMDERR_NOTSUP;
            else if (!halted)
               cmderr_nxt = CMDERR_HALTRESUME;
            else if (kind == KIND_INVALID)
               cmderr_nxt = CMDERR_EXCEPT;
         end
      end else begin
         if ((cmd_wr || data0_wr) && (cmderr == CMDERR_NONE))
            cmderr_nxt = CMDERR_BUSY;
         if ((state == ACCESS) && !halted)
            cmderr_nxt = CMDERR_HALTRESUME;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         data0    <= 32'd0;
         cmderr   <= CMDERR_NONE;
         regno_o  <= 16'd0;
         dbg_addr <= 12'd0;
         write_q  <= 1'b0;
         is_gpr_q <= 1'b0;
`ifdef DBG_AUTOINC_EN
         postinc_q <= 1'b0;
`endif
      end else begin
         cmderr <= cmderr_nxt;
         case (state)
            IDLE: begin
               if (data0_wr)
                  data0 <= data0_wdata;
               if (accept) begin
                  regno_o <= cmd_regno;
                  if (cmd[CMD_TRANSFER]) begin
                     write_q  <= cmd[CMD_WRITE];
                     is_gpr_q <= (kind == KIND_GPR);
                     dbg_addr <= (kind == KIND_GPR) ? {7'd0, gpr_off[4:0]} : cmd_regno[11:0];
`ifdef DBG_AUTOINC_EN
                     postinc_q <= cmd[CMD_POSTINC];
`endif
                     state <= ACCESS;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (halted && !write_q)
                  data0 <= is_gpr_q ? dbg_gpr_out : dbg_csr_out;
`ifdef DBG_AUTOINC_EN
               if (halted && postinc_q)
                  regno_o <= regno_o + 16'd1;
`endif
               state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DBG_AUTOINC_EN
   logic unused_bits;
   assign unused_bits = ^{cmd[23], cmd[18], gpr_off[15:5]};
`else
   logic unused_bits;
   assign unused_bits = ^{cmd[23], cmd[CMD_POSTINC], cmd[18], gpr_off[15:5]};
`endif

endmodule

// File: tb/tb_dbg_abs_cmd.sv
// Directed bench for dbg_abs_cmd: inputs change 1ns after the rising edge, outputs are sampled there.
module tb_dbg_abs_cmd;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_wr;
   logic [31:0] cmd;
   logic        data0_wr;
   logic [31:0] data0_wdata;
   logic [31:0] data0;
   logic        busy;
   logic [2:0]  cmderr;
   logic [2:0]  cmderr_clr;
   logic [15:0] regno_o;
   logic        halted;
   logic [11:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_gpr_rd;
   logic        dbg_gpr_wr;
   logic [31:0] dbg_gpr_out;
   logic        dbg_csr_rd;
   logic        dbg_csr_wr;
   logic [31:0] dbg_csr_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dbg_abs_cmd dut (
      .clk(clk), .rstn(rstn), .cmd_wr(cmd_wr), .cmd(cmd),
      .data0_wr(data0_wr), .data0_wdata(data0_wdata), .data0(data0),
      .busy(busy), .cmderr(cmderr), .cmderr_clr(cmderr_clr), .regno_o(regno_o),
      .halted(halted), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gpr_rd(dbg_gpr_rd), .dbg_gpr_wr(dbg_gpr_wr), .dbg_gpr_out(dbg_gpr_out),
      .dbg_csr_rd(dbg_csr_rd), .dbg_csr_wr(dbg_csr_wr), .dbg_csr_out(dbg_csr_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] c);
      cmd_wr = 1'b1;
      cmd    = c;
      tick();
      cmd_wr = 1'b0;
   endtask

   task automatic clear_err();
      cmderr_clr = 3'b111;
      tick();
      cmderr_clr = 3'b000;
   endtask

   task automatic test_reset();
      rstn = 1'b0; cmd_wr = 1'b0; cmd = 32'd0; data0_wr = 1'b0; data0_wdata = 32'd0;
      cmderr_clr = 3'd0; halted = 1'b1; dbg_gpr_out = 32'd0; dbg_csr_out = 32'd0;
      tick(); tick();
      checks++; if ({data0, busy, cmderr, regno_o} !== {32'd0, 1'b0, 3'd0, 16'd0}) begin
         errors++; $display("FAIL reset_regs: data0=%h busy=%b cmderr=%0d regno=%h, want 0", data0, busy, cmderr, regno_o);
      end
      checks++; if ({dbg_addr, dbg_wdata, dbg_gpr_rd, dbg_gpr_wr, dbg_csr_rd, dbg_csr_wr} !== 48'd0) begin
         errors++; $display("FAIL reset_port: addr=%h wdata=%h strobes=%b%b%b%b, want 0",
                            dbg_addr, dbg_wdata, dbg_gpr_rd, dbg_gpr_wr, dbg_csr_rd, dbg_csr_wr);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_gpr_write();
      data0_wr = 1'b1; data0_wdata = 32'hDEADBEEF;
      tick();
      data0_wr = 1'b0;
      checks++; if (data0 !== 32'hDEADBEEF) begin
         errors++; $display("FAIL data0_write: got %h want deadbeef", data0);
      end
      issue(32'h00231005);
      checks++; if ({dbg_gpr_wr, dbg_gpr_rd, dbg_csr_rd, dbg_csr_wr, dbg_addr, dbg_wdata, busy} !==
                    {4'b1000, 12'd5, 32'hDEADBEEF, 1'b1}) begin
         errors++; $display("FAIL gpr_wr_strobe: strobes=%b%b%b%b addr=%h wdata=%h busy=%b, want 1000 005 deadbeef 1",
                            dbg_gpr_wr, dbg_gpr_rd, dbg_csr_rd, dbg_csr_wr, dbg_addr, dbg_wdata, busy);
      end
      tick();
      checks++; if ({dbg_gpr_wr, busy} !== 2'b01) begin
         errors++; $display("FAIL gpr_wr_resp: gpr_wr=%b busy=%b, want 0 1", dbg_gpr_wr, busy);
      end
      tick();
      checks++; if ({busy, cmderr, regno_o, data0} !== {1'b0, 3'd0, 16'h1005, 32'hDEADBEEF}) begin
         errors++; $display("FAIL gpr_wr_done: busy=%b cmderr=%0d regno=%h data0=%h, want 0 0 1005 deadbeef",
                            busy, cmderr, regno_o, data0);
      end
   endtask

   task automatic test_csr_read();
      dbg_csr_out = 32'h1800;
      issue(32'h00220300);
      checks++; if ({dbg_csr_rd, dbg_csr_wr, dbg_gpr_rd, dbg_gpr_wr, dbg_addr} !== {4'b1000, 12'h300}) begin
         errors++; $display("FAIL csr_rd_strobe: strobes=%b%b%b%b addr=%h, want 1000 300",
                            dbg_csr_rd, dbg_csr_wr, dbg_gpr_rd, dbg_gpr_wr, dbg_addr);
      end
      tick();
      checks++; if ({data0, busy, dbg_csr_rd} !== {32'h1800, 1'b1, 1'b0}) begin
         errors++; $display("FAIL csr_rd_data: data0=%h busy=%b csr_rd=%b, want 00001800 1 0", data0, busy, dbg_csr_rd);
      end
      tick();
      checks++; if (busy !== 1'b0) begin
         errors++; $display("FAIL csr_rd_idle: busy=%b want 0", busy);
      end
      dbg_gpr_out = 32'h12345678;
      issue(32'h0022101F);
      checks++; if ({dbg_gpr_rd, dbg_addr} !== {1'b1, 12'd31}) begin
         errors++; $display("FAIL gpr_rd_strobe: gpr_rd=%b addr=%h, want 1 01f", dbg_gpr_rd, dbg_addr);
      end
      tick(); tick();
      checks++; if ({data0, busy, cmderr} !== {32'h12345678, 1'b0, 3'd0}) begin
         errors++; $display("FAIL gpr_rd_data: data0=%h busy=%b cmderr=%0d, want 12345678 0 0", data0, busy, cmderr);
      end
   endtask

   task automatic test_not_halted();
      halted = 1'b0;
      issue(32'h00221001);
      checks++; if ({busy, cmderr, dbg_gpr_rd} !== {1'b0, 3'd4, 1'b0}) begin
         errors++; $display("FAIL not_halted: busy=%b cmderr=%0d gpr_rd=%b, want 0 4 0", busy, cmderr, dbg_gpr_rd);
      end
      halted = 1'b1;
      issue(32'h00221001);
      checks++; if ({busy, cmderr} !== {1'b0, 3'd4}) begin
         errors++; $display("FAIL sticky_ignore: busy=%b cmderr=%0d, want 0 4", busy, cmderr);
      end
      clear_err();
      checks++; if (cmderr !== 3'd0) begin
         errors++; $display("FAIL err_clear: cmderr=%0d want 0", cmderr);
      end
      issue(32'h00221001);
      checks++; if ({busy, dbg_gpr_rd} !== 2'b11) begin
         errors++; $display("FAIL after_clear: busy=%b gpr_rd=%b, want 1 1", busy, dbg_gpr_rd);
      end
      tick(); tick();
   endtask

   task automatic test_errors();
      issue(32'h00321000);
      checks++; if ({busy, cmderr} !== {1'b0, 3'd2}) begin
         errors++; $display("FAIL aarsize3: busy=%b cmderr=%0d, want 0 2", busy, cmderr);
      end
      clear_err();
      issue(32'h01221000);
      checks++; if (cmderr !== 3'd2) begin
         errors++; $display("FAIL cmdtype1: cmderr=%0d want 2", cmderr);
      end
      clear_err();
      issue(32'h00221020);
      checks++; if ({busy, cmderr} !== {1'b0, 3'd3}) begin
         errors++; $display("FAIL regno_1020: busy=%b cmderr=%0d, want 0 3", busy, cmderr);
      end
      clear_err();
      issue(32'h00222000);
      checks++; if (cmderr !== 3'd3) begin
         errors++; $display("FAIL regno_2000: cmderr=%0d want 3", cmderr);
      end
      clear_err();
      issue(32'h00201005);
      checks++; if ({busy, dbg_gpr_rd, dbg_gpr_wr, dbg_csr_rd, dbg_csr_wr, regno_o} !== {5'b10000, 16'h1005}) begin
         errors++; $display("FAIL no_transfer: busy=%b strobes=%b%b%b%b regno=%h, want 1 0000 1005",
                            busy, dbg_gpr_rd, dbg_gpr_wr, dbg_csr_rd, dbg_csr_wr, regno_o);
      end
      tick();
      checks++; if (busy !== 1'b0) begin
         errors++; $display("FAIL no_transfer_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      dbg_gpr_out = 32'h0000AAAA;
      issue(32'h00221001);
      issue(32'h00220300);
      checks++; if ({busy, cmderr, data0} !== {1'b1, 3'd1, 32'h0000AAAA}) begin
         errors++; $display("FAIL busy_cmd: busy=%b cmderr=%0d data0=%h, want 1 1 0000aaaa", busy, cmderr, data0);
      end
      tick();
      checks++; if ({busy, cmderr} !== {1'b0, 3'd1}) begin
         errors++; $display("FAIL busy_done: busy=%b cmderr=%0d, want 0 1", busy, cmderr);
      end
      clear_err();
      issue(32'h00221002);
      data0_wr = 1'b1; data0_wdata = 32'h55555555; cmderr_clr = 3'b111;
      tick();
      data0_wr = 1'b0; cmderr_clr = 3'b000;
      checks++; if ({cmderr, data0} !== {3'd1, 32'h0000AAAA}) begin
         errors++; $display("FAIL busy_data0_wr: cmderr=%0d data0=%h, want 1 0000aaaa", cmderr, data0);
      end
      tick();
      clear_err();
   endtask

   task automatic test_halt_drop();
      dbg_gpr_out = 32'h99999999;
      issue(32'h00221003);
      halted = 1'b0;
      #1;
      checks++; if ({dbg_gpr_rd, dbg_gpr_wr, dbg_csr_rd, dbg_csr_wr} !== 4'b0000) begin
         errors++; $display("FAIL halt_drop_strobe: strobes=%b%b%b%b want 0000",
                            dbg_gpr_rd, dbg_gpr_wr, dbg_csr_rd, dbg_csr_wr);
      end
      tick();
      checks++; if ({cmderr, data0, busy} !== {3'd4, 32'h0000AAAA, 1'b1}) begin
         errors++; $display("FAIL halt_drop_err: cmderr=%0d data0=%h busy=%b, want 4 0000aaaa 1", cmderr, data0, busy);
      end
      tick();
      checks++; if (busy !== 1'b0) begin
         errors++; $display("FAIL halt_drop_idle: busy=%b want 0", busy);
      end
      halted = 1'b1;
      clear_err();
   endtask

   task automatic test_autoinc();
      dbg_gpr_out = 32'hCAFE0031;
      issue(32'h002A101F);
      tick();
`ifdef DBG_AUTOINC_EN
      checks++; if ({regno_o, data0} !== {16'h1020, 32'hCAFE0031}) begin
         errors++; $display("FAIL postinc: regno=%h data0=%h, want 1020 cafe0031", regno_o, data0);
      end
      tick();
      issue(32'h002A1020);
      checks++; if ({cmderr, busy} !== {3'd3, 1'b0}) begin
         errors++; $display("FAIL postinc_oob: cmderr=%0d busy=%b, want 3 0", cmderr, busy);
      end
      clear_err();
`else
      checks++; if ({regno_o, data0, cmderr} !== {16'h101F, 32'hCAFE0031, 3'd0}) begin
         errors++; $display("FAIL postinc_ignored: regno=%h data0=%h cmderr=%0d, want 101f cafe0031 0",
                            regno_o, data0, cmderr);
      end
      tick();
`endif
   endtask

   task automatic test_reset_abort();
      issue(32'h00231007);
      rstn = 1'b0;
      #1;
      checks++; if ({dbg_gpr_wr, busy, data0} !== {1'b0, 1'b0, 32'd0}) begin
         errors++; $display("FAIL reset_abort: gpr_wr=%b busy=%b data0=%h, want 0 0 0", dbg_gpr_wr, busy, data0);
      end
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_gpr_write();
      test_csr_read();
      test_not_halted();
      test_errors();
      test_back_to_back();
      test_halt_drop();
      test_autoinc();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
